// File: rtl/hs_pkg.sv
// Types shared by the hiscore download and upload paths.
// Holds the FSM state encoding and the region-table entry layout.
package hs_pkg;

   localparam int unsigned HS_START_W = 16;
   localparam int unsigned HS_LEN_W   = 8;

   typedef enum logic [2:0] {
      IDLE,
      PAUSE,
      FETCH,
      WAIT,
      DATA,
      HOLD,
      DONE
   } hs_state_t;

   // One region: start address and length minus one.
   typedef struct packed {
      logic [HS_START_W-1:0] start;
      logic [HS_LEN_W-1:0]   len;
   } hs_region_t;

endpackage

// File: rtl/hs_upload_reader.sv
// Streams hiscore regions of CPU work RAM to the HPS during an ioctl upload,
// one byte per HPS read strobe, holding the CPU paused for the whole stream.
module hs_upload_reader
   import hs_pkg::*;
#(
   parameter int unsigned HS_ADDRESSWIDTH  = 12,
   parameter int unsigned CFG_ADDRESSWIDTH = 2
) (
   input  logic                        clk_sys,
   input  logic                        reset_n,
   input  logic                        cfg_wr,
   input  logic [CFG_ADDRESSWIDTH-1:0] cfg_idx,
   input  logic [HS_ADDRESSWIDTH-1:0]  cfg_start,
   input  logic [7:0]                  cfg_len,
   input  logic [CFG_ADDRESSWIDTH:0]   cfg_count,
   input  logic                        ioctl_upload,
   input  logic                        ioctl_rd,
   output logic [7:0]                  ioctl_din,
   output logic                        pause_req,
   input  logic                        paused,
   output logic [HS_ADDRESSWIDTH-1:0]  ram_address,
   output logic                        ram_read,
   input  logic [7:0]                  data_from_ram,
   output logic                        upload_done,
   output logic                        overrun
);

   localparam int unsigned ENTRIES = 1 << CFG_ADDRESSWIDTH;
   localparam int unsigned EW      = CFG_ADDRESSWIDTH + 1;

   hs_state_t                  state_q, state_d;
   hs_region_t                 table_q [ENTRIES];
   hs_region_t                 cur;
   logic [EW-1:0]              e_q, e_d;
   logic [7:0]                 o_q, o_d;
   logic                       pending_q, pending_d;
   logic                       upload_q;
   logic                       overrun_d, done_d, preq_d, rd_d;
   logic [7:0]                 din_d;
   logic [HS_ADDRESSWIDTH-1:0] addr_d;
   logic                       rise;

   assign cur  = table_q[e_q[CFG_ADDRESSWIDTH-1:0]];
   assign rise = ioctl_upload & ~upload_q;

   // Region table: writable only while no session is running.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(ENTRIES); i++) table_q[i] <= '0;
      end else if (cfg_wr && state_q == IDLE) begin
         table_q[cfg_idx] <= '{start: HS_START_W'(cfg_start), len: cfg_len};
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         e_q         <= '0;
         o_q         <= '0;
         pending_q   <= 1'b0;
         upload_q    <= 1'b0;
         overrun     <= 1'b0;
         upload_done <= 1'b0;
         ioctl_din   <= '0;
         pause_req   <= 1'b0;
         ram_address <= '0;
         ram_read    <= 1'b0;
      end else begin
         state_q     <= state_d;
         e_q         <= e_d;
         o_q         <= o_d;
         pending_q   <= pending_d;
         upload_q    <= ioctl_upload;
         overrun     <= overrun_d;
         upload_done <= done_d;
         ioctl_din   <= din_d;
         pause_req   <= preq_d;
         ram_address <= addr_d;
         ram_read    <= rd_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      e_d       = e_q;
      o_d       = o_q;
      pending_d = pending_q;
      overrun_d = overrun;
      done_d    = upload_done;
      din_d     = ioctl_din;
      preq_d    = pause_req;
      addr_d    = ram_address;
      rd_d      = 1'b0;

      if (state_q != IDLE && !ioctl_upload) begin
         state_d   = IDLE;
         preq_d    = 1'b0;
         pending_d = 1'b0;
      end else begin
         // Early strobe is remembered; a second one before service is lost.
         if (ioctl_rd && (state_q inside {PAUSE, FETCH, WAIT, DATA})) begin
            if (pending_q) overrun_d = 1'b1;
            pending_d = 1'b1;
         end

         case (state_q)
            IDLE: begin
               if (rise) begin
                  e_d       = '0;
                  o_d       = '0;
                  overrun_d = 1'b0;
                  done_d    = 1'b0;
                  pending_d = 1'b0;
                  if (cfg_count == '0) begin
                     state_d = DONE;
                     done_d  = 1'b1;
                     din_d   = '0;
                  end else begin
                     state_d = PAUSE;
                     preq_d  = 1'b1;
                  end
               end
            end
            PAUSE: begin
               if (paused) state_d = FETCH;
            end
            FETCH: begin
               if (paused) begin
                  addr_d  = HS_ADDRESSWIDTH'(cur.start + HS_START_W'(o_q));
                  rd_d    = 1'b1;
                  state_d = WAIT;
               end
            end
            WAIT: state_d = DATA;
            DATA: begin
               din_d = data_from_ram;
               if (o_q == cur.len) begin
                  o_d = '0;
                  e_d = e_q + EW'(1);
               end else begin
                  o_d = o_q + 8'd1;
               end
               state_d = HOLD;
            end
            HOLD: begin
               if (ioctl_rd || pending_q) begin
                  pending_d = 1'b0;
                  if (ioctl_rd && pending_q) overrun_d = 1'b1;
                  // Pointer already advanced past the byte on ioctl_din.
                  if (e_q == cfg_count) begin
                     state_d = DONE;
                     done_d  = 1'b1;
                     preq_d  = 1'b0;
                     din_d   = '0;
                  end else begin
                     state_d = FETCH;
                  end
               end
            end
            DONE: ;
            default: state_d = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hs_upload_reader.sv
// Directed bench for hs_upload_reader with a behavioural 1-cycle RAM.
module tb_hs_upload_reader;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        cfg_wr;
   logic [1:0]  cfg_idx;
   logic [11:0] cfg_start;
   logic [7:0]  cfg_len;
   logic [2:0]  cfg_count;
   logic        ioctl_upload;
   logic        ioctl_rd;
   logic [7:0]  ioctl_din;
   logic        pause_req;
   logic        paused;
   logic [11:0] ram_address;
   logic        ram_read;
   logic [7:0]  data_from_ram;
   logic        upload_done;
   logic        overrun;

   int total = 0;
   int bad   = 0;

   hs_upload_reader #(.HS_ADDRESSWIDTH(12), .CFG_ADDRESSWIDTH(2)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_start(cfg_start),
      .cfg_len(cfg_len), .cfg_count(cfg_count),
      .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd), .ioctl_din(ioctl_din),
      .pause_req(pause_req), .paused(paused),
      .ram_address(ram_address), .ram_read(ram_read),
      .data_from_ram(data_from_ram),
      .upload_done(upload_done), .overrun(overrun)
   );

   always #5 clk_sys = ~clk_sys;

   function automatic logic [7:0] ram_f(input logic [11:0] a);
      return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h3C;
   endfunction

   // RAM returns garbage unless the read intent was asserted.
   always @(posedge clk_sys) begin
      if (ram_read) data_from_ram <= ram_f(ram_address);
      else          data_from_ram <= 8'hEE;
   end

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cfg_entry(input logic [1:0] idx, input logic [11:0] st, input logic [7:0] ln);
      cfg_wr = 1'b1; cfg_idx = idx; cfg_start = st; cfg_len = ln;
      step();
      cfg_wr = 1'b0;
   endtask

   task automatic pulse_rd();
      ioctl_rd = 1'b1;
      step();
      ioctl_rd = 1'b0;
   endtask

   task automatic expect_byte(input string tag, input logic [11:0] addr);
      repeat (5) step();
      chk({tag, "_din"}, 32'(ioctl_din), 32'(ram_f(addr)));
      chk({tag, "_addr"}, 32'(ram_address), 32'(addr));
      chk({tag, "_notdone"}, 32'(upload_done), 32'd0);
      chk({tag, "_preq"}, 32'(pause_req), 32'd1);
      pulse_rd();
   endtask

   task automatic expect_done(input string tag);
      chk({tag, "_done"}, 32'(upload_done), 32'd1);
      chk({tag, "_din0"}, 32'(ioctl_din), 32'd0);
      chk({tag, "_preq0"}, 32'(pause_req), 32'd0);
   endtask

   task automatic end_session();
      ioctl_upload = 1'b0;
      step();
   endtask

   initial begin
      reset_n = 1'b0; cfg_wr = 1'b0; cfg_idx = '0; cfg_start = '0; cfg_len = '0;
      cfg_count = '0; ioctl_upload = 1'b0; ioctl_rd = 1'b0; paused = 1'b1;
      #12;
      chk("rst_din", 32'(ioctl_din), 32'd0);
      chk("rst_preq", 32'(pause_req), 32'd0);
      chk("rst_addr", 32'(ram_address), 32'd0);
      chk("rst_read", 32'(ram_read), 32'd0);
      chk("rst_done", 32'(upload_done), 32'd0);
      chk("rst_ovr", 32'(overrun), 32'd0);
      reset_n = 1'b1;
      step();

      // Single entry of three bytes.
      cfg_entry(2'd0, 12'h100, 8'd2);
      cfg_count = 3'd1;
      ioctl_upload = 1'b1;
      step();
      chk("t1_preq_start", 32'(pause_req), 32'd1);
      chk("t1_noread", 32'(ram_read), 32'd0);
      expect_byte("t1_b0", 12'h100);
      expect_byte("t1_b1", 12'h101);
      expect_byte("t1_b2", 12'h102);
      expect_done("t1");
      end_session();

      // Address wrap across the top of RAM.
      cfg_entry(2'd0, 12'hFFE, 8'd3);
      ioctl_upload = 1'b1;
      step();
      expect_byte("t2_b0", 12'hFFE);
      expect_byte("t2_b1", 12'hFFF);
      expect_byte("t2_b2", 12'h000);
      expect_byte("t2_b3", 12'h001);
      expect_done("t2");
      end_session();

      // Two entries, CPU slow to pause.
      cfg_entry(2'd0, 12'h010, 8'd0);
      cfg_entry(2'd1, 12'h200, 8'd1);
      cfg_count = 3'd2;
      paused = 1'b0;
      ioctl_upload = 1'b1;
      step();
      for (int i = 0; i < 10; i++) begin
         chk("t3_no_early_read", 32'(ram_read), 32'd0);
         step();
      end
      chk("t3_preq_wait", 32'(pause_req), 32'd1);
      paused = 1'b1;
      expect_byte("t3_b0", 12'h010);
      expect_byte("t3_b1", 12'h200);
      expect_byte("t3_b2", 12'h201);
      expect_done("t3");
      end_session();

      // Empty table goes straight to done.
      cfg_count = 3'd0;
      ioctl_upload = 1'b1;
      step();
      expect_done("t4");
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t4_preq_never", 32'(pause_req), 32'd0);
      end
      end_session();

      // Early strobe in WAIT is serviced once HOLD is reached.
      cfg_entry(2'd0, 12'h300, 8'd1);
      cfg_count = 3'd1;
      ioctl_upload = 1'b1;
      step();
      step();
      step();
      ioctl_rd = 1'b1;
      step();
      ioctl_rd = 1'b0;
      step();
      chk("t5_b0_din", 32'(ioctl_din), 32'(ram_f(12'h300)));
      repeat (4) step();
      chk("t5_b1_din", 32'(ioctl_din), 32'(ram_f(12'h301)));
      chk("t5_no_ovr", 32'(overrun), 32'd0);
      pulse_rd();
      expect_done("t5");
      end_session();

      // Back-to-back strobes raise overrun; then abort mid-stream.
      ioctl_upload = 1'b1;
      step();
      ioctl_rd = 1'b1;
      step();
      step();
      ioctl_rd = 1'b0;
      chk("t6_ovr", 32'(overrun), 32'd1);
      ioctl_upload = 1'b0;
      step();
      chk("t6_abort_preq", 32'(pause_req), 32'd0);
      chk("t6_abort_read", 32'(ram_read), 32'd0);
      chk("t6_ovr_hold", 32'(overrun), 32'd1);
      ioctl_upload = 1'b1;
      step();
      chk("t6_ovr_clear", 32'(overrun), 32'd0);
      expect_byte("t6_b0", 12'h300);
      expect_byte("t6_b1", 12'h301);
      expect_done("t6");
      end_session();

      // Reset asserted while stuck in FETCH.
      paused = 1'b0;
      ioctl_upload = 1'b1;
      step();
      step();
      paused = 1'b1;
      step();
      paused = 1'b0;
      step();
      chk("t7_preq_pre", 32'(pause_req), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("t7_rst_preq", 32'(pause_req), 32'd0);
      chk("t7_rst_addr", 32'(ram_address), 32'd0);
      chk("t7_rst_read", 32'(ram_read), 32'd0);
      chk("t7_rst_din", 32'(ioctl_din), 32'd0);
      chk("t7_rst_done", 32'(upload_done), 32'd0);
      chk("t7_rst_ovr", 32'(overrun), 32'd0);
      reset_n = 1'b1;
      ioctl_upload = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
